// File: rtl/dequant_unpack.sv
// rtl/dequant_unpack.sv - serializes packed quantized words and widens each lane to the array format
module dequant_unpack #(
    parameter int Q_DW  = 8,
    parameter int Q_IT  = 4,
    parameter int Q_PC  = 3,
    parameter int W_DW  = 24,
    parameter int W_IT  = 17,
    parameter int W_PC  = 6,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*Q_DW-1:0] in_data,
    input  logic [LANES-1:0]      in_keep,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W_DW-1:0]       out_data,
    output logic                  out_last
);
    localparam int LPW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SH  = W_PC - Q_PC;

    if (Q_DW != Q_IT + Q_PC + 1 || W_DW != W_IT + W_PC + 1 || W_IT < Q_IT || W_PC < Q_PC) begin : g_bad_params
        $error("dequant_unpack: inconsistent format parameters");
    end

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [LANES*Q_DW-1:0] data_q, data_d;
    logic [LANES-1:0]      keep_q, keep_d;
    logic                  last_q, last_d;
    logic [LPW-1:0]        lp_q, lp_d;

    logic                  word_vld;
    logic                  is_last_lane;
    logic                  elem_xfer;
    logic                  word_xfer;
    logic [Q_DW-1:0]       elem;
    logic [W_DW-1:0]       elem_ext;

    always_comb begin
        word_vld     = (state_q == HOLD);
        elem         = '0;
        is_last_lane = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (lp_q == LPW'(k)) elem = data_q[k*Q_DW +: Q_DW];
            if (keep_q[k] && (LPW'(k) > lp_q)) is_last_lane = 1'b0;
        end
        // Sign-extend, then align the binary point by padding fraction LSBs with zeros.
        elem_ext  = {{(W_DW-Q_DW){elem[Q_DW-1]}}, elem};
        out_valid = word_vld;
        out_data  = word_vld ? (elem_ext << SH) : '0;
        out_last  = word_vld & last_q & is_last_lane;
        in_ready  = !word_vld | (out_ready & is_last_lane);
        elem_xfer = word_vld & out_ready;
        word_xfer = in_valid & in_ready;

        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        lp_d    = lp_q;
        if (word_xfer && (in_keep != '0)) begin
            state_d = HOLD;
            data_d  = in_data;
            keep_d  = in_keep;
            last_d  = in_last;
            lp_d    = '0;
        end else if (elem_xfer && is_last_lane) begin
            state_d = EMPTY;
        end else if (elem_xfer) begin
            // Kept lanes are contiguous, so the next set keep bit is simply lp+1.
            lp_d = lp_q + LPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            lp_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            lp_q    <= lp_d;
        end
    end
endmodule

// File: tb/tb_dequant_unpack.sv
// tb/tb_dequant_unpack.sv - directed self-checking bench for dequant_unpack
module tb_dequant_unpack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [3:0]  in_keep = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic        out_last;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [31:0] WORD_A = 32'h01_80_7F_00;
    localparam logic [31:0] WORD_B = 32'h40_C0_FF_01;

    dequant_unpack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    a_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)))
        else $error("FAIL out_stable: element changed or dropped while stalled");

    a_keep: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready) |-> ((in_keep & (in_keep + 4'd1)) == 4'd0))
        else $error("FAIL keep_contig: non-contiguous in_keep %b", in_keep);

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_last, out_data, in_ready} !== {1'b0, 1'b0, 24'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: got v=%b l=%b d=%h rdy=%b, want v=0 l=0 d=000000 rdy=1",
                     out_valid, out_last, out_data, in_ready);
        end
    endtask

    task automatic test_single_word();
        logic [23:0] exp_d [4] = '{24'h000000, 24'h0003F8, 24'hFFFC00, 24'h000008};
        @(negedge clk);
        in_valid = 1'b1; in_data = WORD_A; in_keep = 4'hF; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_cmp++;
            if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, exp_d[k]}) begin
                n_fail++;
                $display("FAIL single lane%0d: got v=%b l=%b d=%h, want v=1 l=0 d=%h",
                         k, out_valid, out_last, out_data, exp_d[k]);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_d [8] = '{24'h000000, 24'h0003F8, 24'hFFFC00, 24'h000008,
                                   24'h000008, 24'hFFFFF8, 24'hFFFE00, 24'h000200};
        logic exp_r, exp_l;
        @(negedge clk);
        in_valid = 1'b1; in_data = WORD_A; in_keep = 4'hF; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin in_data = WORD_B; in_last = 1'b1; end
            if (k == 5) in_valid = 1'b0;
            #1;
            exp_r = (k == 4) || (k == 8);
            exp_l = (k == 8);
            n_cmp++;
            if ({out_valid, out_last, out_data, in_ready} !== {1'b1, exp_l, exp_d[k-1], exp_r}) begin
                n_fail++;
                $display("FAIL b2b elem%0d: got v=%b l=%b d=%h rdy=%b, want v=1 l=%b d=%h rdy=%b",
                         k, out_valid, out_last, out_data, in_ready, exp_l, exp_d[k-1], exp_r);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_partial_keep();
        logic [23:0] exp_d [2] = '{24'hFFFFC0, 24'h000080};
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0000_10F8; in_keep = 4'b0011; in_last = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_cmp++;
            if ({out_valid, out_last, out_data, in_ready} !== {1'b1, k == 1, exp_d[k], k == 1}) begin
                n_fail++;
                $display("FAIL partial lane%0d: got v=%b l=%b d=%h rdy=%b, want v=1 l=%b d=%h rdy=%b",
                         k, out_valid, out_last, out_data, in_ready, k == 1, exp_d[k], k == 1);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [23:0] exp_d [6] = '{24'h000000, 24'h0003F8, 24'h0003F8, 24'h0003F8, 24'hFFFC00, 24'h000008};
        logic        rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        in_valid = 1'b1; in_data = WORD_A; in_keep = 4'hF; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = rdy_pat[k];
            #1;
            n_cmp++;
            if ({out_valid, out_data, in_ready} !== {1'b1, exp_d[k], k == 5}) begin
                n_fail++;
                $display("FAIL stall cyc%0d: got v=%b d=%h rdy=%b, want v=1 d=%h rdy=%b",
                         k, out_valid, out_data, in_ready, exp_d[k], k == 5);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = WORD_A; in_keep = 4'hF; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_data !== 24'h0003F8) begin
            n_fail++;
            $display("FAIL midrst_lane1: got d=%h, want d=0003f8", out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, in_ready} !== {1'b0, 24'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_after: got v=%b d=%h rdy=%b, want v=0 d=000000 rdy=1",
                     out_valid, out_data, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = WORD_B; in_keep = 4'hF; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 24'h000008}) begin
            n_fail++;
            $display("FAIL midrst_restart: got v=%b d=%h, want v=1 d=000008", out_valid, out_data);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_zero_keep();
        logic [23:0] exp_d [4] = '{24'h000008, 24'hFFFFF8, 24'hFFFE00, 24'h000200};
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_keep = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_keep_rdy: got rdy=%b, want rdy=1", in_ready);
        end
        @(negedge clk);
        in_data = WORD_B; in_keep = 4'hF;
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_keep_drop: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_cmp++;
            if ({out_valid, out_data} !== {1'b1, exp_d[k]}) begin
                n_fail++;
                $display("FAIL zero_keep_next lane%0d: got v=%b d=%h, want v=1 d=%h",
                         k, out_valid, out_data, exp_d[k]);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_keep_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial_keep();
        test_stall();
        test_mid_reset();
        test_zero_keep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dequant_unpack.md
Name: dequant_unpack

Overview:
- Streaming dequantizer on the operand-fetch path, between the quantized output/activation buffer and the systolic array input.
- Accepts packed words of LANES signed Q_DW-bit fixed-point values (Q_IT integer, Q_PC fraction, plus a sign bit).
- Serializes each word one element per cycle and widens every element exactly to the W_DW-bit array format (W_IT integer, W_PC fraction, plus a sign bit).
- This is the inverse of the array's round/saturate quantizer. Widening is lossless; no rounding and no saturation.

Parameters:
- Q_DW, 8, quantized element width (Q_DW = Q_IT + Q_PC + 1).
- Q_IT, 4, quantized integer bits.
- Q_PC, 3, quantized fraction bits.
- W_DW, 24, widened element width (W_DW = W_IT + W_PC + 1).
- W_IT, 17, widened integer bits; must be >= Q_IT.
- W_PC, 6, widened fraction bits; must be >= Q_PC.
- LANES, 4, elements per packed input word.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  packed word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  LANES*Q_DW  packed word; lane k = in_data[k*Q_DW +: Q_DW]; lane 0 is sent first.
- in_keep  in  LANES  per-lane enable; kept lanes are contiguous from lane 0.
- in_last  in  1  word ends the tensor/row.
- out_valid  out  1  widened element valid.
- out_ready  in  1  downstream accepts the element.
- out_data  out  W_DW  widened signed element.
- out_last  out  1  marks the final kept element of a word that arrived with in_last=1.

Behaviour:
- State: word register (data, keep, last), word_vld flag, lane pointer lp (clog2(LANES) bits).
- Two states:
  - EMPTY: word_vld=0.
  - HOLD: word_vld=1, lp selects the current lane.
- Reset (rst=1 at a clock edge):
  - word_vld=0, lp=0, word register cleared.
  - Outputs: out_valid=0, out_last=0, out_data=0. in_ready is 1 on the first cycle after reset.
  - Reset mid-word discards the remaining lanes; nothing partial is emitted after reset.
- Output drive:
  - out_valid = word_vld.
  - out_data = the lane-lp element, sign-extended to W_DW, then shifted left by (W_PC - Q_PC), with zeros filled in at the LSBs.
  - out_data = 0 whenever out_valid=0.
- Arithmetic: numeric value is preserved exactly. Defaults: shift 3, sign extension from bit 7 to bit 23.
- Last-lane definition: is_last_lane = no keep_q bit is set above lp.
- out_last = word_vld & last_q & is_last_lane.
- Handshake:
  - An element transfers when out_valid & out_ready.
  - A word transfers when in_valid & in_ready.
  - in_ready = !word_vld | (out_ready & is_last_lane). This is the only combinational in->out path; in_valid never feeds out_* combinationally.
- Latency and throughput:
  - A word accepted at edge t presents lane 0 at cycle t+1.
  - Back-to-back words stream with zero bubbles: N kept lanes per word -> N cycles per word.
- Transitions:
  - EMPTY + word transfer with keep!=0 -> HOLD, lp=0.
  - HOLD + element transfer, not last lane -> lp = next set keep bit above lp.
  - HOLD + element transfer on last lane:
    - simultaneous word transfer with keep!=0 -> HOLD, lp=0, new word loaded;
    - otherwise -> EMPTY.
  - HOLD with out_ready=0: all state holds; out_data/out_last stable.
- Zero-keep word (in_keep=0): accepted and dropped. It produces no output, and its in_last is lost; upstream must not send it with in_last=1.
- keep_q lane 0 is always 1 while in HOLD. Non-contiguous keep is illegal and is caught by an assertion in simulation.
- Valid/ready stability: out_valid, once high, stays high until transfer. The bench checks this with an assertion.

Test Plan:
- Reset then in_data=0x01_80_7F_00, keep=4'hF, last=0, out_ready=1 -> out_data sequence 0x000000, 0x0003F8, 0xFFFC00, 0x000008 on 4 consecutive cycles, starting 1 cycle after accept; out_last=0 throughout.
- Two back-to-back full words, second with in_last=1, out_ready=1 -> 8 contiguous valid cycles; in_ready high on the last lane of word 1; out_last only on element 8.
- keep=4'b0011, last=1, data lanes 0xF8, 0x10 -> 0xFFFFC0, then 0x000080 with out_last=1; in_ready=1 on that cycle.
- out_ready toggled 1,0,0,1 during a word -> each element held stable while stalled; no loss or duplication; in_ready=0 until the last lane transfers.
- rst asserted after lane 1 of a full word -> next cycle out_valid=0, out_data=0, in_ready=1; a new word starts again at lane 0.
- in_keep=0 word followed by a full word -> no output for the first word; second word's lane 0 appears 1 cycle after its accept.
